// File: rtl/pipe_pkg.sv
// Shared types and default widths for the pipeline memory stage.
package pipe_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned REG_W_DEF  = 5;
  localparam int unsigned CNT_W      = 32;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

  // M/WB register contents at the default widths
  typedef struct packed {
    logic                  regwr;
    logic                  memtoreg;
    logic [REG_W_DEF-1:0]  rd;
    logic [DATA_W_DEF-1:0] aluout;
    logic [DATA_W_DEF-1:0] memdata;
  } mwb_t;

endpackage

// File: rtl/mem_wb_register.sv
// M/WB pipeline register: inserts a bubble while the memory stage stalls,
// and refreshes the load data only when a load actually completes.
module mem_wb_register
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned REG_W  = REG_W_DEF
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              bubble,
  input  logic              load_done,
  input  logic              regwr_d,
  input  logic              memtoreg_d,
  input  logic [REG_W-1:0]  rd_d,
  input  logic [DATA_W-1:0] aluout_d,
  input  logic [DATA_W-1:0] memdata_d,
  output logic              regwr_q,
  output logic              memtoreg_q,
  output logic [REG_W-1:0]  rd_q,
  output logic [DATA_W-1:0] aluout_q,
  output logic [DATA_W-1:0] memdata_q
);

  always_ff @(negedge CLK or posedge Reset) begin
    if (Reset) begin
      regwr_q    <= 1'b0;
      memtoreg_q <= 1'b0;
      rd_q       <= '0;
      aluout_q   <= '0;
      memdata_q  <= '0;
    end else if (bubble) begin
      // write-back controls killed, payload held
      regwr_q    <= 1'b0;
      memtoreg_q <= 1'b0;
    end else begin
      regwr_q    <= regwr_d;
      memtoreg_q <= memtoreg_d;
      rd_q       <= rd_d;
      aluout_q   <= aluout_d;
      if (load_done) memdata_q <= memdata_d;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: variable-latency data-memory handshake, upstream stall,
// branch/jump redirect and M/WB register. Optional stall counter: MEM_STALL_CNT_EN.
module mem_stage
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned REG_W  = REG_W_DEF
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [DATA_W-1:0] busB_M,
  input  logic [DATA_W-1:0] ALUout_M,
  input  logic [ADDR_W-1:0] Target_M,
  input  logic [REG_W-1:0]  Rd_M,
  input  logic              MemtoReg_M,
  input  logic              RegWr_M,
  input  logic              Jump_M,
  input  logic              Branch_M,
  input  logic              MemWr_M,
  input  logic              Zero_M,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ready,
  output logic              Stall_M,
  output logic              PCSrc_M,
  output logic [ADDR_W-1:0] Target_out,
  output logic              MisalignErr,
  output logic              RegWr_WB,
  output logic              MemtoReg_WB,
  output logic [REG_W-1:0]  Rd_WB,
  output logic [DATA_W-1:0] ALUout_WB,
  output logic [DATA_W-1:0] MemData_WB,
  output logic [CNT_W-1:0]  StallCnt
);

  mem_state_e state_q, state_d;
  logic mem_op, misaligned, load_done;

  assign mem_op     = MemWr_M | MemtoReg_M;
  assign misaligned = mem_op & (ALUout_M[1:0] != 2'b00);

  always_ff @(negedge CLK or posedge Reset) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (dmem_req && !dmem_ready) state_d = WAIT;
      WAIT:    if (dmem_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request is gated by Reset so it drops without waiting for the flop
  always_comb begin
    dmem_req = 1'b0;
    case (state_q)
      IDLE:    dmem_req = mem_op & ~misaligned;
      WAIT:    dmem_req = 1'b1;
      default: dmem_req = 1'b0;
    endcase
    if (Reset) dmem_req = 1'b0;
  end

  assign dmem_we    = MemWr_M;
  assign dmem_addr  = ADDR_W'(ALUout_M);
  assign dmem_wdata = busB_M;
  assign Stall_M    = dmem_req & ~dmem_ready;
  assign PCSrc_M    = ((Branch_M & Zero_M) | Jump_M) & ~Stall_M;
  assign Target_out = Target_M;
  assign load_done  = MemtoReg_M & dmem_req & dmem_ready;

  always_ff @(negedge CLK or posedge Reset) begin
    if (Reset) MisalignErr <= 1'b0;
    else       MisalignErr <= misaligned;
  end

`ifdef MEM_STALL_CNT_EN
  always_ff @(negedge CLK or posedge Reset) begin
    if (Reset)                           StallCnt <= '0;
    else if (Stall_M && (StallCnt != '1)) StallCnt <= StallCnt + CNT_W'(1);
  end
`else
  assign StallCnt = '0;
`endif

  mem_wb_register #(
    .DATA_W(DATA_W),
    .REG_W (REG_W)
  ) u_mem_wb (
    .CLK        (CLK),
    .Reset      (Reset),
    .bubble     (Stall_M),
    .load_done  (load_done),
    .regwr_d    (RegWr_M & ~misaligned),
    .memtoreg_d (MemtoReg_M),
    .rd_d       (Rd_M),
    .aluout_d   (ALUout_M),
    .memdata_d  (dmem_rdata),
    .regwr_q    (RegWr_WB),
    .memtoreg_q (MemtoReg_WB),
    .rd_q       (Rd_WB),
    .aluout_q   (ALUout_WB),
    .memdata_q  (MemData_WB)
  );

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: table of single-cycle vectors plus
// hand-written multi-cycle stall and reset sequences.
module tb_mem_stage;
  import pipe_pkg::*;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [31:0] busB_M, ALUout_M, Target_M, dmem_rdata;
  logic [4:0]  Rd_M;
  logic        MemtoReg_M, RegWr_M, Jump_M, Branch_M, MemWr_M, Zero_M, dmem_ready;
  logic        dmem_req, dmem_we, Stall_M, PCSrc_M, MisalignErr, RegWr_WB, MemtoReg_WB;
  logic [31:0] dmem_addr, dmem_wdata, Target_out, ALUout_WB, MemData_WB, StallCnt;
  logic [4:0]  Rd_WB;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_cnt  = 0;

  mem_stage dut (
    .CLK(CLK), .Reset(Reset), .busB_M(busB_M), .ALUout_M(ALUout_M), .Target_M(Target_M),
    .Rd_M(Rd_M), .MemtoReg_M(MemtoReg_M), .RegWr_M(RegWr_M), .Jump_M(Jump_M),
    .Branch_M(Branch_M), .MemWr_M(MemWr_M), .Zero_M(Zero_M), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready), .Stall_M(Stall_M),
    .PCSrc_M(PCSrc_M), .Target_out(Target_out), .MisalignErr(MisalignErr),
    .RegWr_WB(RegWr_WB), .MemtoReg_WB(MemtoReg_WB), .Rd_WB(Rd_WB),
    .ALUout_WB(ALUout_WB), .MemData_WB(MemData_WB), .StallCnt(StallCnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] alu, busb, tgt;
    logic [4:0]  rd;
    logic        m2r, regwr, jump, branch, memwr, zero;
    logic [31:0] rdata;
    logic        ready;
    logic        e_req, e_pcsrc, e_regwr;
    logic [31:0] e_memdata;
    logic        e_mis;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic [31:0] alu, busb, tgt, input logic [4:0] rd,
                              input logic m2r, regwr, jump, branch, memwr, zero,
                              input logic [31:0] rdata, input logic ready,
                              input logic e_req, e_pcsrc, e_regwr,
                              input logic [31:0] e_memdata, input logic e_mis);
    vec_t v;
    v.alu = alu; v.busb = busb; v.tgt = tgt; v.rd = rd;
    v.m2r = m2r; v.regwr = regwr; v.jump = jump; v.branch = branch;
    v.memwr = memwr; v.zero = zero; v.rdata = rdata; v.ready = ready;
    v.e_req = e_req; v.e_pcsrc = e_pcsrc; v.e_regwr = e_regwr;
    v.e_memdata = e_memdata; v.e_mis = e_mis;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic drive(input vec_t v);
    ALUout_M = v.alu; busB_M = v.busb; Target_M = v.tgt; Rd_M = v.rd;
    MemtoReg_M = v.m2r; RegWr_M = v.regwr; Jump_M = v.jump; Branch_M = v.branch;
    MemWr_M = v.memwr; Zero_M = v.zero; dmem_rdata = v.rdata; dmem_ready = v.ready;
  endtask

  task automatic chk_cnt(input string name);
`ifdef MEM_STALL_CNT_EN
    chk(name, StallCnt, 32'(exp_cnt));
`else
    chk(name, StallCnt, 32'd0);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            alu         busb        tgt       rd    m2r rw j b mw z  rdata        rdy req pc rwb memdata     mis
    vecs[0] = mk(32'h10,      32'h0,      32'h0,    5'd5, 1, 1, 0, 0, 0, 0, 32'hDEADBEEF, 1, 1, 0, 1, 32'hDEADBEEF, 0);
    vecs[1] = mk(32'h55,      32'h0,      32'h0,    5'd3, 0, 1, 0, 0, 0, 0, 32'hFFFF0000, 1, 0, 0, 1, 32'hDEADBEEF, 0);
    vecs[2] = mk(32'h0,       32'h0,      32'h40,   5'd0, 0, 0, 0, 1, 0, 1, 32'h0,        0, 0, 1, 0, 32'hDEADBEEF, 0);
    vecs[3] = mk(32'h0,       32'h0,      32'h40,   5'd0, 0, 0, 0, 1, 0, 0, 32'h0,        0, 0, 0, 0, 32'hDEADBEEF, 0);
    vecs[4] = mk(32'h0,       32'h0,      32'h80,   5'd0, 0, 0, 1, 0, 0, 0, 32'h0,        0, 0, 1, 0, 32'hDEADBEEF, 0);
    vecs[5] = mk(32'h13,      32'h0,      32'h0,    5'd7, 1, 1, 0, 0, 0, 0, 32'h11111111, 1, 0, 0, 0, 32'hDEADBEEF, 1);
    vecs[6] = mk(32'h4,       32'h0,      32'h0,    5'd2, 0, 1, 0, 0, 0, 0, 32'h0,        0, 0, 0, 1, 32'hDEADBEEF, 0);
    vecs[7] = mk(32'h22,      32'h99,     32'h0,    5'd0, 0, 0, 0, 0, 1, 0, 32'h0,        1, 0, 0, 0, 32'hDEADBEEF, 1);
    vecs[8] = mk(32'h24,      32'hABCD,   32'h0,    5'd0, 0, 0, 0, 0, 1, 0, 32'h0,        1, 1, 0, 0, 32'hDEADBEEF, 0);
    vecs[9] = mk(32'h30,      32'h0,      32'h0,    5'd9, 1, 1, 0, 0, 0, 0, 32'hCAFEF00D, 1, 1, 0, 1, 32'hCAFEF00D, 0);

    Reset = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(negedge CLK);
    #1;
    chk("rst.RegWr_WB", 32'(RegWr_WB), 32'd0);
    chk("rst.ALUout_WB", ALUout_WB, 32'd0);
    chk("rst.MemData_WB", MemData_WB, 32'd0);
    chk("rst.MisalignErr", 32'(MisalignErr), 32'd0);
    chk_cnt("rst.StallCnt");
    @(posedge CLK); #1;
    Reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(posedge CLK); #1;
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d.req", i),      32'(dmem_req), 32'(vecs[i].e_req));
      chk($sformatf("v%0d.we", i),       32'(dmem_we),  32'(vecs[i].memwr));
      chk($sformatf("v%0d.addr", i),     dmem_addr,     vecs[i].alu);
      chk($sformatf("v%0d.wdata", i),    dmem_wdata,    vecs[i].busb);
      chk($sformatf("v%0d.stall", i),    32'(Stall_M),  32'd0);
      chk($sformatf("v%0d.pcsrc", i),    32'(PCSrc_M),  32'(vecs[i].e_pcsrc));
      chk($sformatf("v%0d.target", i),   Target_out,    vecs[i].tgt);
      @(negedge CLK); #1;
      chk($sformatf("v%0d.RegWr_WB", i),    32'(RegWr_WB),    32'(vecs[i].e_regwr));
      chk($sformatf("v%0d.MemtoReg_WB", i), 32'(MemtoReg_WB), 32'(vecs[i].m2r));
      chk($sformatf("v%0d.Rd_WB", i),       32'(Rd_WB),       32'(vecs[i].rd));
      chk($sformatf("v%0d.ALUout_WB", i),   ALUout_WB,        vecs[i].alu);
      chk($sformatf("v%0d.MemData_WB", i),  MemData_WB,       vecs[i].e_memdata);
      chk($sformatf("v%0d.MisalignErr", i), 32'(MisalignErr), 32'(vecs[i].e_mis));
    end
    chk_cnt("tbl.StallCnt");

    // Store to 0x20, memory ready after three wait cycles
    for (int c = 0; c < 4; c++) begin
      @(posedge CLK); #1;
      drive(mk(32'h20, 32'h1234, 0, 0, 0, 0, 0, 0, 1, 0, 0, (c == 3), 0, 0, 0, 0, 0));
      #1;
      chk($sformatf("st%0d.stall", c), 32'(Stall_M),  32'(c < 3));
      chk($sformatf("st%0d.req", c),   32'(dmem_req), 32'd1);
      chk($sformatf("st%0d.we", c),    32'(dmem_we),  32'd1);
      chk($sformatf("st%0d.addr", c),  dmem_addr,     32'h20);
      chk($sformatf("st%0d.wdata", c), dmem_wdata,    32'h1234);
      @(negedge CLK); #1;
      if (c < 3) begin
        exp_cnt++;
        chk($sformatf("st%0d.bubble_rw", c),  32'(RegWr_WB),    32'd0);
        chk($sformatf("st%0d.bubble_m2r", c), 32'(MemtoReg_WB), 32'd0);
        chk($sformatf("st%0d.hold_alu", c),   ALUout_WB,        32'h30);
        chk($sformatf("st%0d.hold_rd", c),    32'(Rd_WB),       32'd9);
      end else begin
        chk("st.done_alu", ALUout_WB, 32'h20);
        chk("st.done_rw",  32'(RegWr_WB), 32'd0);
      end
    end
    chk_cnt("st.StallCnt");

    // Load from 0x40 with one wait cycle; data captured only on completion
    for (int c = 0; c < 2; c++) begin
      @(posedge CLK); #1;
      drive(mk(32'h40, 0, 0, 5'd4, 1, 1, 0, 0, 0, 0,
               (c == 0) ? 32'h0BAD0BAD : 32'h600DF00D, (c == 1), 0, 0, 0, 0, 0));
      #1;
      chk($sformatf("ld%0d.stall", c), 32'(Stall_M), 32'(c == 0));
      @(negedge CLK); #1;
      if (c == 0) begin
        exp_cnt++;
        chk("ld0.MemData_WB", MemData_WB, 32'hCAFEF00D);
        chk("ld0.RegWr_WB",   32'(RegWr_WB), 32'd0);
      end else begin
        chk("ld1.MemData_WB", MemData_WB, 32'h600DF00D);
        chk("ld1.RegWr_WB",   32'(RegWr_WB), 32'd1);
        chk("ld1.Rd_WB",      32'(Rd_WB), 32'd4);
      end
    end
    chk_cnt("ld.StallCnt");

    // Reset asserted while a load sits in WAIT
    @(posedge CLK); #1;
    drive(mk(32'h50, 0, 0, 5'd6, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("rw.stall_pre", 32'(Stall_M), 32'd1);
    @(negedge CLK);
    @(posedge CLK); #1;
    chk("rw.req_wait", 32'(dmem_req), 32'd1);
    Reset = 1'b1;
    #1;
    chk("rw.req",         32'(dmem_req),    32'd0);
    chk("rw.stall",       32'(Stall_M),     32'd0);
    chk("rw.RegWr_WB",    32'(RegWr_WB),    32'd0);
    chk("rw.MemtoReg_WB", 32'(MemtoReg_WB), 32'd0);
    chk("rw.Rd_WB",       32'(Rd_WB),       32'd0);
    chk("rw.ALUout_WB",   ALUout_WB,        32'd0);
    chk("rw.MemData_WB",  MemData_WB,       32'd0);
    chk("rw.StallCnt",    StallCnt,         32'd0);
    @(negedge CLK);
    @(posedge CLK); #1;
    Reset = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("rw.idle_req", 32'(dmem_req), 32'd0);
    @(negedge CLK); #1;
    chk("rw.idle_cnt", StallCnt, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
